alu_share_arbiter: RTL and testbench

//  Shares one combinational alu instance between two requesters (port 0: EX-stage issue,

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_share_arbiter_if.sv | 38 +++
 rtl/alu_share_arbiter_alu.sv | 27 ++
 rtl/alu_share_arbiter.sv | 100 ++++++++++
 tb/tb_alu_share_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state type for the shared-ALU arbiter.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd6;
    localparam logic [2:0] ALU_SLE = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two requesters and the shared-ALU arbiter.
interface alu_share_arbiter_if #(parameter int WIDTH = 32);

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_ctrl;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_ctrl;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_result, rsp_zero, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_result, rsp_zero, busy
    );

endinterface

// File: rtl/alu_share_arbiter_alu.sv
// Combinational ALU shared by both requesters; unknown opcodes yield zero.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] Read_data_1,
    input  logic [WIDTH-1:0] Data_2,
    input  logic [2:0]       ALU_control,
    output logic [WIDTH-1:0] Result,
    output logic             Zero_flag
);

    always_comb begin
        Result = '0;
        case (ALU_control)
            ALU_AND: Result = Read_data_1 & Data_2;
            ALU_OR:  Result = Read_data_1 | Data_2;
            ALU_ADD: Result = Read_data_1 + Data_2;
            ALU_SUB: Result = Read_data_1 - Data_2;
            ALU_SLE: Result = (Read_data_1 > Data_2) ? '0 : {{(WIDTH-1){1'b0}}, 1'b1};
            default: Result = '0;
        endcase
        Zero_flag = (Result == '0);
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Arbitrates two valid/ready requesters onto one ALU and returns a registered
// result to the granted port only.
//   state | meaning
//   IDLE  | no result held, any valid request is accepted
//   HOLD  | result held for owner until its rsp_ready
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter bit RR_EN = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    alu_share_arbiter_if.slave  bus
);

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic             pick1;
    logic             owner_ready;
    logic             can_accept;
    logic             accept;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic [2:0]       alu_ctrl;
    logic             alu_zero;

    // Ready is a function of valids and held state only, never of ready itself.
    always_comb begin
        pick1       = bus.req1_valid & (~bus.req0_valid | (RR_EN & rr_ptr_q));
        owner_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
        can_accept  = (state_q == IDLE) | ((state_q == HOLD) & owner_ready);
        bus.req0_ready = can_accept & bus.req0_valid & ~pick1;
        bus.req1_ready = can_accept & pick1;
        accept      = can_accept & (bus.req0_valid | bus.req1_valid);
        alu_a       = pick1 ? bus.req1_a    : bus.req0_a;
        alu_b       = pick1 ? bus.req1_b    : bus.req0_b;
        alu_ctrl    = pick1 ? bus.req1_ctrl : bus.req0_ctrl;
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .Read_data_1 (alu_a),
        .Data_2      (alu_b),
        .ALU_control (alu_ctrl),
        .Result      (alu_result),
        .Zero_flag   (alu_zero)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = HOLD;
            end
            HOLD: begin
                if (!accept && owner_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Last winner loses the next tie.
        if (accept) begin
            owner_d  = pick1;
            rr_ptr_d = ~pick1;
            result_d = alu_result;
            zero_d   = alu_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        bus.rsp0_valid = (state_q == HOLD) & ~owner_q;
        bus.rsp1_valid = (state_q == HOLD) & owner_q;
        bus.rsp_result = result_q;
        bus.rsp_zero   = zero_q;
        bus.busy       = (state_q == HOLD);
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench: one round-robin and one fixed-priority instance share stimulus.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [31:0] req_a [2];
    logic [31:0] req_b [2];
    logic [2:0]  req_ctrl [2];
    logic [1:0]  rsp_ready = 2'b11;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(32)) if_rr ();
    alu_share_arbiter_if #(.WIDTH(32)) if_fp ();

    assign if_rr.req0_valid = req_valid[0];
    assign if_rr.req0_a     = req_a[0];
    assign if_rr.req0_b     = req_b[0];
    assign if_rr.req0_ctrl  = req_ctrl[0];
    assign if_rr.req1_valid = req_valid[1];
    assign if_rr.req1_a     = req_a[1];
    assign if_rr.req1_b     = req_b[1];
    assign if_rr.req1_ctrl  = req_ctrl[1];
    assign if_rr.rsp0_ready = rsp_ready[0];
    assign if_rr.rsp1_ready = rsp_ready[1];
    assign if_fp.req0_valid = req_valid[0];
    assign if_fp.req0_a     = req_a[0];
    assign if_fp.req0_b     = req_b[0];
    assign if_fp.req0_ctrl  = req_ctrl[0];
    assign if_fp.req1_valid = req_valid[1];
    assign if_fp.req1_a     = req_a[1];
    assign if_fp.req1_b     = req_b[1];
    assign if_fp.req1_ctrl  = req_ctrl[1];
    assign if_fp.rsp0_ready = rsp_ready[0];
    assign if_fp.rsp1_ready = rsp_ready[1];

    alu_share_arbiter #(.WIDTH(32), .RR_EN(1'b1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(if_rr));
    alu_share_arbiter #(.WIDTH(32), .RR_EN(1'b0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(if_fp));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] c);
        case (c)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd6:    return a - b;
            3'd7:    return (a > b) ? 32'd0 : 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    // Model: index 0 = round-robin instance, 1 = fixed-priority instance.
    bit          m_held [2];
    int          m_owner [2];
    logic [31:0] m_res [2];
    bit          m_zero [2];
    int          m_pref [2];

    // Port served this cycle, or -1 if nobody is served.
    function automatic int model_grant(input int k);
        if (req_valid == 2'b00) return -1;
        if (m_held[k] && !rsp_ready[m_owner[k]]) return -1;
        if (req_valid == 2'b11) return (k == 0) ? m_pref[k] : 0;
        return req_valid[0] ? 0 : 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_held[k] = 0; m_owner[k] = 0; m_res[k] = 0; m_zero[k] = 0; m_pref[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int g;
                g = model_grant(k);
                if (g >= 0) begin
                    m_held[k]  = 1;
                    m_owner[k] = g;
                    m_res[k]   = alu_ref(req_a[g], req_b[g], req_ctrl[g]);
                    m_zero[k]  = (m_res[k] == 0);
                    m_pref[k]  = 1 - g;
                end else if (m_held[k] && rsp_ready[m_owner[k]]) begin
                    m_held[k] = 0;
                end
            end
        end
    end

    task automatic cmp_inst(input string tag, input int k, input logic r0, input logic r1,
                            input logic v0, input logic v1, input logic b,
                            input logic [31:0] res, input logic z);
        int g;
        g = model_grant(k);
        check({tag, " req0_ready"}, {31'd0, r0}, {31'd0, g == 0});
        check({tag, " req1_ready"}, {31'd0, r1}, {31'd0, g == 1});
        check({tag, " rsp0_valid"}, {31'd0, v0}, {31'd0, m_held[k] && m_owner[k] == 0});
        check({tag, " rsp1_valid"}, {31'd0, v1}, {31'd0, m_held[k] && m_owner[k] == 1});
        check({tag, " busy"}, {31'd0, b}, {31'd0, m_held[k]});
        if (m_held[k]) begin
            check({tag, " rsp_result"}, res, m_res[k]);
            check({tag, " rsp_zero"}, {31'd0, z}, {31'd0, m_zero[k]});
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            cmp_inst("rr", 0, if_rr.req0_ready, if_rr.req1_ready, if_rr.rsp0_valid,
                     if_rr.rsp1_valid, if_rr.busy, if_rr.rsp_result, if_rr.rsp_zero);
            cmp_inst("fp", 1, if_fp.req0_ready, if_fp.req1_ready, if_fp.rsp0_valid,
                     if_fp.rsp1_valid, if_fp.busy, if_fp.rsp_result, if_fp.rsp_zero);
        end
    end

    // Requester protocol on the round-robin instance: a stalled request must not change.
    logic [1:0]  p_stall = '0;
    logic [31:0] p_a [2];
    logic [31:0] p_b [2];
    logic [2:0]  p_c [2];
    always @(posedge clk) begin
        if (rst_n) begin
            for (int n = 0; n < 2; n++) begin
                if (p_stall[n])
                    assert (req_valid[n] && req_a[n] == p_a[n] && req_b[n] == p_b[n]
                            && req_ctrl[n] == p_c[n])
                    else $error("FAIL protocol port%0d changed while stalled", n);
            end
        end
        p_stall[0] = rst_n && req_valid[0] && !if_rr.req0_ready;
        p_stall[1] = rst_n && req_valid[1] && !if_rr.req1_ready;
        for (int n = 0; n < 2; n++) begin
            p_a[n] = req_a[n]; p_b[n] = req_b[n]; p_c[n] = req_ctrl[n];
        end
    end

    task automatic drive(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] c);
        req_valid[p] = 1'b1; req_a[p] = a; req_b[p] = b; req_ctrl[p] = c;
    endtask

    // One uncontested request on port p, checked against hand-computed values.
    task automatic single(input string name, input int p, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] c,
                          input logic [31:0] exp_res, input logic exp_zero);
        @(posedge clk); #1;
        drive(p, a, b, c);
        @(negedge clk);
        check({name, " accepted"}, {31'd0, p == 0 ? if_rr.req0_ready : if_rr.req1_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        @(negedge clk);
        check({name, " own valid"}, {31'd0, p == 0 ? if_rr.rsp0_valid : if_rr.rsp1_valid}, 32'd1);
        check({name, " other valid"}, {31'd0, p == 0 ? if_rr.rsp1_valid : if_rr.rsp0_valid}, 32'd0);
        check({name, " result"}, if_rr.rsp_result, exp_res);
        check({name, " zero"}, {31'd0, if_rr.rsp_zero}, {31'd0, exp_zero});
    endtask

    // Drop each request only in the cycle it is accepted by the round-robin instance.
    task automatic drain();
        int cyc;
        logic c0, c1;
        cyc = 0;
        while (req_valid != 2'b00 && cyc < 10) begin
            @(negedge clk);
            c0 = if_rr.req0_ready; c1 = if_rr.req1_ready;
            @(posedge clk); #1;
            if (c0) req_valid[0] = 1'b0;
            if (c1) req_valid[1] = 1'b0;
            cyc++;
        end
        if (req_valid != 2'b00) check("drain timeout", {30'd0, req_valid}, 32'd0);
    endtask

    initial begin
        int grants [4];
        for (int n = 0; n < 2; n++) begin
            req_a[n] = '0; req_b[n] = '0; req_ctrl[n] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("reset rsp0_valid", {31'd0, if_rr.rsp0_valid}, 32'd0);
        check("reset rsp1_valid", {31'd0, if_rr.rsp1_valid}, 32'd0);
        check("reset busy", {31'd0, if_rr.busy}, 32'd0);
        check("reset result", if_rr.rsp_result, 32'd0);
        check("reset zero", {31'd0, if_rr.rsp_zero}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Contention: port 0 ADD 5+5, port 1 SUB 7-7, every cycle.
        @(posedge clk); #1;
        drive(0, 32'd5, 32'd5, 3'd2);
        drive(1, 32'd7, 32'd7, 3'd6);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("rr resp valid", {31'd0, grants[i-1] == 0 ? if_rr.rsp0_valid : if_rr.rsp1_valid}, 32'd1);
                check("rr resp result", if_rr.rsp_result, grants[i-1] == 0 ? 32'd10 : 32'd0);
                check("rr resp zero", {31'd0, if_rr.rsp_zero}, grants[i-1] == 0 ? 32'd0 : 32'd1);
            end
            grants[i] = if_rr.req1_ready ? 1 : (if_rr.req0_ready ? 0 : -1);
            check("fp port0 always", {31'd0, if_fp.req0_ready}, 32'd1);
            check("fp port1 starved", {31'd0, if_fp.req1_ready}, 32'd0);
            @(posedge clk); #1;
        end
        check("rr grant0", grants[0], 32'd0);
        check("rr grant1", grants[1], 32'd1);
        check("rr grant2", grants[2], 32'd0);
        check("rr grant3", grants[3], 32'd1);
        drain();

        single("add3p4", 0, 32'd3, 32'd4, 3'd2, 32'd7, 1'b0);
        single("add wrap", 0, 32'hFFFF_FFFF, 32'd1, 3'd2, 32'd0, 1'b1);
        single("sub wrap", 1, 32'd0, 32'd1, 3'd6, 32'hFFFF_FFFF, 1'b0);
        single("bad ctrl", 0, 32'd5, 32'd6, 3'd3, 32'd0, 1'b1);
        single("and", 1, 32'h0000_F0F0, 32'h0000_FF00, 3'd0, 32'h0000_F000, 1'b0);
        single("or", 0, 32'h0000_00F0, 32'h0000_000F, 3'd1, 32'h0000_00FF, 1'b0);
        single("sle gt", 0, 32'd9, 32'd2, 3'd7, 32'd0, 1'b1);
        single("sle eq", 1, 32'd2, 32'd2, 3'd7, 32'd1, 1'b0);

        // Backpressure: port 1 result held while port 0 waits.
        @(posedge clk); #1;
        rsp_ready[1] = 1'b0;
        drive(1, 32'd4, 32'd7, 3'd7);
        @(negedge clk);
        check("bp accept", {31'd0, if_rr.req1_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        drive(0, 32'd1, 32'd2, 3'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp rsp1_valid", {31'd0, if_rr.rsp1_valid}, 32'd1);
            check("bp result held", if_rr.rsp_result, 32'd1);
            check("bp req0_ready", {31'd0, if_rr.req0_ready}, 32'd0);
            check("bp req1_ready", {31'd0, if_rr.req1_ready}, 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        check("bp release grant", {31'd0, if_rr.req0_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("bp next result", if_rr.rsp_result, 32'd3);
        check("bp next owner", {31'd0, if_rr.rsp0_valid}, 32'd1);

        // Reset while a result is held.
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        drive(0, 32'd20, 32'd22, 3'd2);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("pre-reset held", {31'd0, if_rr.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst rsp0_valid", {31'd0, if_rr.rsp0_valid}, 32'd0);
        check("async rst busy", {31'd0, if_rr.busy}, 32'd0);
        check("async rst result", if_rr.rsp_result, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        rsp_ready[0] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("post-reset no rsp", {30'd0, if_rr.rsp1_valid, if_rr.rsp0_valid}, 32'd0);
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
